// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, default clock/baud
// constants and the data width. Used by both the transmitter and receiver.
// Optional build macro: UART_TX_PARITY_EN adds the PARITY state and helper.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_CLK_FRQ_HZ = 10_000_000;
    localparam int UART_BAUD_RATE  = 115_200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_tx_state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic uart_parity(input logic [UART_DATA_W-1:0] data,
                                         input logic                   odd);
        return (^data) ^ odd;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, flagging `tick`
// on the last clock of each bit. `restart` holds the count at zero so the
// first bit after it gets a full period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 86
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Next count: wrap on the bit boundary, park at zero while restarting.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter with a one-entry holding register so frames
// go out back-to-back. Default frame is 8N1; defining UART_TX_PARITY_EN
// inserts a parity bit (even, or odd when PARITY_ODD=1) for 8E1/8O1.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FRQ_HZ   = UART_CLK_FRQ_HZ,
    parameter int BAUD_RATE    = UART_BAUD_RATE,
    parameter int CLKS_PER_BIT = CLK_FRQ_HZ / BAUD_RATE,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    input  logic [UART_DATA_W-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   tx,
    output logic                   tx_busy,
    output logic                   tx_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_t         state_q, state_d;
    logic [UART_DATA_W-1:0] hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    logic tick;
    logic handshake;
    logic load;

    // Counter sits at zero in IDLE so a fresh frame starts on a full period.
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (state_q == ST_IDLE),
        .tick    (tick)
    );

    assign handshake = tx_valid && !hold_full_q;
    assign load      = hold_full_q &&
                       ((state_q == ST_IDLE) || (state_q == ST_STOP && tick));

    assign tx_ready = !hold_full_q;
    assign tx       = tx_q;
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_done  = (state_q == ST_STOP) && tick;

    // State register plus datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Next-state: each non-idle state lasts one bit period; STOP chains
    // straight into START when a byte is waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (hold_full_q) state_d = ST_START;
            ST_START:  if (tick) state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_DATA:   if (tick && bit_idx_q == 3'd7) state_d = ST_PARITY;
            ST_PARITY: if (tick) state_d = ST_STOP;
`else
            ST_DATA:   if (tick && bit_idx_q == 3'd7) state_d = ST_STOP;
`endif
            ST_STOP:   if (tick) state_d = hold_full_q ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Holding register, shift register and bit index updates.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        if (handshake) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bit_idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            parity_d    = uart_parity(hold_q, 1'(PARITY_ODD));
`endif
        end else if (state_q == ST_DATA && tick) begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
        end
    end

    // Line level registered from the next state so tx lines up with state_q.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at default rates (86 clocks per bit).
module tb_uart_tx;

    localparam int CPB  = 86;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FLEN = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx, tx_busy, tx_done;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(
        .CLK_FRQ_HZ (10_000_000),
        .BAUD_RATE  (115_200),
        .PARITY_ODD (PODD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a byte until accepted; t_acc is the cycle of the accepting edge.
    task automatic send(input logic [7:0] b, output int t_acc);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (!tx_ready && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) chk("send_timeout_ready", int'(tx_ready), 1);
        step();
        t_acc    = cyc;
        tx_valid = 1'b0;
        tx_data  = ~b;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 3000) begin
            step();
            n++;
        end
        chk(tag, int'(tx), 0);
    endtask

    // Called on the first start-bit clock; ends on the last stop-bit clock.
    task automatic check_frame(input string tag, input logic [7:0] b, output int rdy_cnt);
        logic [NBITS-1:0] bits;
        int good [NBITS];
        int done_bad, busy_cnt;
        bits     = '1;
        bits[0]  = 1'b0;
        bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
        bits[9]  = (^b) ^ 1'(PODD);
`endif
        for (int i = 0; i < NBITS; i++) good[i] = 0;
        done_bad = 0;
        busy_cnt = 0;
        rdy_cnt  = 0;
        for (int k = 0; k < FLEN; k++) begin
            if (k > 0) step();
            if (tx === bits[k / CPB]) good[k / CPB]++;
            if (tx_done !== (k == FLEN - 1)) done_bad++;
            if (tx_ready === 1'b1) rdy_cnt++;
            if (tx_busy === 1'b1) busy_cnt++;
        end
        for (int i = 0; i < NBITS; i++)
            chk($sformatf("%s_bit%0d", tag, i), good[i], CPB);
        chk({tag, "_done_pos"}, done_bad, 0);
        chk({tag, "_busy"}, busy_cnt, FLEN);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish, checks %0d errors %0d", n_chk, n_err);
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, r, z, d;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(tx_ready), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_done", int'(tx_done), 0);
        rst = 1'b0;
        step();

        // Idle stability
        z = 0; d = 0;
        repeat (2000) begin
            step();
            if (tx !== 1'b1) z++;
            if (tx_done !== 1'b0) d++;
        end
        chk("idle_tx_low", z, 0);
        chk("idle_done", d, 0);

        // Single byte 0x55, one clock acceptance-to-start latency
        send(8'h55, t0);
        chk("s55_pre_tx", int'(tx), 1);
        step();
        chk("s55_latency", int'(tx), 0);
        chk("s55_ready", int'(tx_ready), 1);
        check_frame("s55", 8'h55, r);
        chk("s55_ready_cnt", r, FLEN);
        step();
        chk("s55_idle_tx", int'(tx), 1);
        chk("s55_idle_busy", int'(tx_busy), 0);

        // Back-to-back 0xA5, 0x3C with tx_valid held high
        fork
            begin
                send(8'hA5, t0);
                send(8'h3C, t1);
            end
            begin
                wait_start("b2b_start");
                check_frame("b2b1", 8'hA5, r);
                chk("b2b1_ready_cnt", r, 1);
                step();
                chk("b2b_gap", int'(tx), 0);
                check_frame("b2b2", 8'h3C, r);
                chk("b2b2_ready_cnt", r, FLEN);
            end
        join
        chk("b2b_accept_dly", t1 - t0, 2);
        step();
        chk("b2b_idle_tx", int'(tx), 1);
        chk("b2b_idle_busy", int'(tx_busy), 0);

        // Backpressure: 0x01, 0x02, 0x03 offered continuously
        fork
            begin
                send(8'h01, t0);
                send(8'h02, t1);
                send(8'h03, t2);
            end
            begin
                wait_start("bp_start");
                check_frame("bp1", 8'h01, r);
                step();
                chk("bp_gap12", int'(tx), 0);
                check_frame("bp2", 8'h02, r);
                step();
                chk("bp_gap23", int'(tx), 0);
                check_frame("bp3", 8'h03, r);
            end
        join
        chk("bp_accept2", t1 - t0, 2);
        chk("bp_accept3", t2 - t0, FLEN + 2);
        step();
        chk("bp_idle_busy", int'(tx_busy), 0);

        // 0x07 (parity 1 for even when parity is compiled in)
        send(8'h07, t0);
        step();
        check_frame("p07", 8'h07, r);
        step();
        chk("p07_idle_tx", int'(tx), 1);

        // Reset at clock 300 of a 0xFF frame with 0x81 pending
        send(8'hFF, t0);
        send(8'h81, t1);
        repeat (298) step();
        chk("mr_busy_pre", int'(tx_busy), 1);
        chk("mr_ready_pre", int'(tx_ready), 0);
        rst = 1'b1;
        step();
        chk("mr_tx", int'(tx), 1);
        chk("mr_ready", int'(tx_ready), 1);
        chk("mr_busy", int'(tx_busy), 0);
        chk("mr_done", int'(tx_done), 0);
        rst = 1'b0;
        z = 0; d = 0;
        repeat (2 * FLEN) begin
            step();
            if (tx !== 1'b1) z++;
            if (tx_done !== 1'b0) d++;
        end
        chk("mr_no_pending_tx", z, 0);
        chk("mr_no_done", d, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
